// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage RV32I pipeline: operand forwarding, ALU, branch/jump
// resolution and the EX/MEM pipeline register.
module execute_cycle #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            ALUSrcE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic [1:0]      ResultSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [REGW-1:0] RD_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            ZeroE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [REGW-1:0] RD_M
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } aluOp_t;

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] srcAE;
  logic [XLEN-1:0] srcBE;
  logic [XLEN-1:0] writeDataE;
  logic [XLEN-1:0] aluResultE;

  // The M-stage source is the registered ALUResultM, so forwarding never loops through the ALU.
  always_comb begin
    case (ForwardAE)
      2'b10:   srcAE = ALUResultM;
      2'b01:   srcAE = ResultW;
      default: srcAE = RD1_E;
    endcase
  end

  always_comb begin
    case (ForwardBE)
      2'b10:   writeDataE = ALUResultM;
      2'b01:   writeDataE = ResultW;
      default: writeDataE = RD2_E;
    endcase
  end

  assign srcBE = ALUSrcE ? Imm_Ext_E : writeDataE;

  always_comb begin
    aluResultE = '0;
    case (aluOp_t'(ALUControlE))
      ALU_ADD: aluResultE = srcAE + srcBE;
      ALU_SUB: aluResultE = srcAE - srcBE;
      ALU_AND: aluResultE = srcAE & srcBE;
      ALU_OR:  aluResultE = srcAE | srcBE;
      ALU_XOR: aluResultE = srcAE ^ srcBE;
      ALU_SLT: aluResultE = {{(XLEN-1){1'b0}}, ($signed(srcAE) < $signed(srcBE))};
      ALU_SLL: aluResultE = srcAE << srcBE[SHW-1:0];
      ALU_SRL: aluResultE = srcAE >> srcBE[SHW-1:0];
      default: aluResultE = '0;
    endcase
  end

  assign ZeroE     = (aluResultE == '0);
  assign PCTargetE = PCE + Imm_Ext_E;
  assign PCSrcE    = (BranchE & ZeroE) | JumpE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RD_M       <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      ALUResultM <= aluResultE;
      WriteDataM <= writeDataE;
      PCPlus4M   <= PCPlus4E;
      RD_M       <= RD_E;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// Randomized and directed bench for execute_cycle against an arithmetic reference model.
module tb_execute_cycle;

  logic        clk, rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, JumpE, BranchE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic        PCSrcE, ZeroE, RegWriteM, MemWriteM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;

  execute_cycle #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E),
    .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ZeroE(ZeroE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RD_M(RD_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        regWrite, aluSrc, memWrite, jump, branch;
    logic [1:0]  resultSrc;
    logic [2:0]  aluCtl;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rd;
    logic [31:0] pc, pcPlus4;
    logic [1:0]  fwdA, fwdB;
    logic [31:0] resultW;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference copy of the EX/MEM register contents
  logic        mRegWrite, mMemWrite;
  logic [1:0]  mResultSrc;
  logic [31:0] mAlu, mWd, mPc4;
  logic [4:0]  mRd;

  logic        obsPcSrc;
  logic [31:0] obsTarget;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] pickOperand(input logic [1:0] sel, input logic [31:0] regVal,
                                              input logic [31:0] wbVal, input logic [31:0] memVal);
    if (sel == 2'b10) return memVal;
    if (sel == 2'b01) return wbVal;
    return regVal;
  endfunction

  function automatic logic [31:0] refAlu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd6: return a << (b % 32);
      default: return a >> (b % 32);
    endcase
  endfunction

  task automatic driveInputs(input vec_t v);
    RegWriteE = v.regWrite; ALUSrcE = v.aluSrc; MemWriteE = v.memWrite;
    JumpE = v.jump; BranchE = v.branch; ResultSrcE = v.resultSrc;
    ALUControlE = v.aluCtl; RD1_E = v.rd1; RD2_E = v.rd2; Imm_Ext_E = v.imm;
    RD_E = v.rd; PCE = v.pc; PCPlus4E = v.pcPlus4;
    ForwardAE = v.fwdA; ForwardBE = v.fwdB; ResultW = v.resultW;
  endtask

  task automatic checkMState(input string tag);
    checkOutput({tag, ".RegWriteM"}, {31'd0, RegWriteM}, {31'd0, mRegWrite});
    checkOutput({tag, ".MemWriteM"}, {31'd0, MemWriteM}, {31'd0, mMemWrite});
    checkOutput({tag, ".ResultSrcM"}, {30'd0, ResultSrcM}, {30'd0, mResultSrc});
    checkOutput({tag, ".ALUResultM"}, ALUResultM, mAlu);
    checkOutput({tag, ".WriteDataM"}, WriteDataM, mWd);
    checkOutput({tag, ".PCPlus4M"}, PCPlus4M, mPc4);
    checkOutput({tag, ".RD_M"}, {27'd0, RD_M}, {27'd0, mRd});
  endtask

  // Drives one instruction between edges, checks the combinational outputs, then the M stage after the edge.
  task automatic applyStimulus(input string tag, input vec_t v);
    logic [31:0] a, wd, b, res, target;
    logic        pcSrc;
    driveInputs(v);
    a      = pickOperand(v.fwdA, v.rd1, v.resultW, mAlu);
    wd     = pickOperand(v.fwdB, v.rd2, v.resultW, mAlu);
    b      = v.aluSrc ? v.imm : wd;
    res    = refAlu(v.aluCtl, a, b);
    target = v.pc + v.imm;
    pcSrc  = (v.branch && res == 32'd0) || v.jump;
    #1;
    obsPcSrc  = PCSrcE;
    obsTarget = PCTargetE;
    checkOutput({tag, ".ZeroE"}, {31'd0, ZeroE}, {31'd0, (res == 32'd0)});
    checkOutput({tag, ".PCSrcE"}, {31'd0, PCSrcE}, {31'd0, pcSrc});
    checkOutput({tag, ".PCTargetE"}, PCTargetE, target);
    @(posedge clk);
    mRegWrite = v.regWrite; mMemWrite = v.memWrite; mResultSrc = v.resultSrc;
    mAlu = res; mWd = wd; mPc4 = v.pcPlus4; mRd = v.rd;
    #1;
    checkMState(tag);
  endtask

  task automatic clearModel();
    mRegWrite = 1'b0; mMemWrite = 1'b0; mResultSrc = '0;
    mAlu = '0; mWd = '0; mPc4 = '0; mRd = '0;
  endtask

  initial begin
    vec_t v;
    rst = 1'b0;
    v = '0;
    driveInputs(v);
    clearModel();
    #1;
    checkMState("reset");
    #1 rst = 1'b1;

    // add 5 + 7, then forward that result from M into A and add 1
    v = '0; v.regWrite = 1'b1; v.rd1 = 32'd5; v.rd2 = 32'd7; v.rd = 5'd3;
    v.pc = 32'h40; v.pcPlus4 = 32'h44;
    applyStimulus("add", v);
    checkOutput("addConst", ALUResultM, 32'd12);
    checkOutput("addWd", WriteDataM, 32'd7);
    v = '0; v.regWrite = 1'b1; v.fwdA = 2'b10; v.aluSrc = 1'b1; v.imm = 32'd1; v.rd = 5'd4;
    applyStimulus("fwdM", v);
    checkOutput("fwdMConst", ALUResultM, 32'd13);

    v = '0; v.rd1 = 32'd5; v.rd2 = 32'd7; v.aluCtl = 3'b001;
    applyStimulus("sub", v);
    checkOutput("subConst", ALUResultM, 32'hFFFF_FFFE);

    v = '0; v.rd1 = 32'hFFFF_FFFF; v.rd2 = 32'd1; v.aluCtl = 3'b101;
    applyStimulus("slt", v);
    checkOutput("sltConst", ALUResultM, 32'd1);

    // store with forwarded data from W while the ALU takes the immediate
    v = '0; v.memWrite = 1'b1; v.aluSrc = 1'b1; v.fwdB = 2'b01; v.resultW = 32'hAA;
    v.rd1 = 32'd1; v.rd2 = 32'h55; v.imm = 32'd4;
    applyStimulus("store", v);
    checkOutput("storeWd", WriteDataM, 32'hAA);
    checkOutput("storeAddr", ALUResultM, 32'd5);

    v = '0; v.branch = 1'b1; v.aluCtl = 3'b001; v.rd1 = 32'd9; v.rd2 = 32'd9;
    v.pc = 32'h100; v.imm = 32'h20;
    applyStimulus("beqTaken", v);
    checkOutput("beqTakenConst", {31'd0, obsPcSrc}, 32'd1);
    checkOutput("beqTargetConst", obsTarget, 32'h120);
    v.rd2 = 32'd8;
    applyStimulus("beqNot", v);
    checkOutput("beqNotConst", {31'd0, obsPcSrc}, 32'd0);

    v = '0; v.jump = 1'b1; v.regWrite = 1'b1; v.resultSrc = 2'b10;
    v.pc = 32'hFFFF_FFF0; v.pcPlus4 = 32'hFFFF_FFF4; v.imm = 32'h20; v.rd1 = 32'd3;
    applyStimulus("jal", v);
    checkOutput("jalTargetConst", obsTarget, 32'h10);
    checkOutput("jalPc4Const", PCPlus4M, 32'hFFFF_FFF4);

    v = '0; v.fwdA = 2'b11; v.fwdB = 2'b11; v.rd1 = 32'd3; v.rd2 = 32'd4; v.resultW = 32'd99;
    applyStimulus("fwd11", v);
    checkOutput("fwd11Const", ALUResultM, 32'd7);

    v = '0; v.aluCtl = 3'b110; v.aluSrc = 1'b1; v.rd1 = 32'd1; v.imm = 32'd33;
    applyStimulus("sll33", v);
    checkOutput("sll33Const", ALUResultM, 32'd2);

    // asynchronous reset in the middle of an instruction with live M contents
    v = '0; v.regWrite = 1'b1; v.memWrite = 1'b1; v.rd1 = 32'h1234; v.rd2 = 32'h10;
    v.rd = 5'd7; v.pcPlus4 = 32'h88; v.resultSrc = 2'b01;
    applyStimulus("preReset", v);
    driveInputs(v);
    #1 rst = 1'b0;
    #1;
    clearModel();
    checkMState("midReset");
    #1 rst = 1'b1;
    applyStimulus("postReset", v);

    for (int i = 0; i < 300; i++) begin
      v = '0;
      v.regWrite = 1'($urandom); v.aluSrc = 1'($urandom); v.memWrite = 1'($urandom);
      v.jump = ($urandom_range(7) == 0); v.branch = 1'($urandom);
      v.resultSrc = 2'($urandom); v.aluCtl = 3'($urandom);
      v.rd1 = $urandom; v.rd2 = $urandom; v.imm = $urandom; v.rd = 5'($urandom);
      v.pc = $urandom; v.pcPlus4 = v.pc + 32'd4;
      v.fwdA = 2'($urandom); v.fwdB = 2'($urandom); v.resultW = $urandom;
      if ($urandom_range(3) == 0) begin
        v.rd2 = v.rd1; v.fwdA = 2'b00; v.fwdB = 2'b00; v.aluSrc = 1'b0; v.aluCtl = 3'b001;
      end
      if ($urandom_range(3) == 0) v.imm = 32'($urandom_range(40));
      applyStimulus("rand", v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
